// File: rtl/dom_pkg.sv
// dom_pkg: field constants and elaboration-time helpers shared by the DOM GF(2^N) multipliers.
package dom_pkg;
    localparam logic [2:0] POLY_GF4  = 3'b111;
    localparam logic [4:0] POLY_GF16 = 5'b10011;

    function automatic int num_pairs(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Lexicographic index of the unordered pair {i,j}, i != j
    function automatic int pair_idx(input int i, input int j, input int shares);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (2 * shares - lo - 1) / 2 + hi - lo - 1;
    endfunction

    // Horner-style shift-and-add, reducing whenever the degree reaches n
    function automatic logic [3:0] gf2n_mul(input logic [3:0] a, input logic [3:0] b,
                                            input int n, input logic [4:0] poly);
        logic [4:0] acc;
        acc = '0;
        for (int k = 3; k >= 0; k--) begin
            if (k < n) begin
                acc = acc << 1;
                if (acc[n]) acc ^= poly;
                if (b[k]) acc ^= {1'b0, a};
            end
        end
        return acc[3:0];
    endfunction
endpackage

// File: rtl/gf2n_mul.sv
// gf2n_mul: combinational polynomial-basis multiply in GF(2^N) modulo POLY.
module gf2n_mul #(
    parameter int         N    = 4,
    parameter logic [N:0] POLY = 5'b10011
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q
);
    assign q = N'(dom_pkg::gf2n_mul(4'(a), 4'(b), N, 5'(POLY)));
endmodule

// File: rtl/dom_shared_mul_gf2n.sv
// dom_shared_mul_gf2n: DOM-masked GF(2^N) multiplier with per-term resharing registers
// and a stallable one-cycle valid pipeline.
module dom_shared_mul_gf2n import dom_pkg::*; #(
    parameter int         N         = 4,
    parameter logic [N:0] POLY      = (N == 2) ? (N+1)'(POLY_GF4) : (N+1)'(POLY_GF16),
    parameter int         SHARES    = 2,
    parameter bit         PIPELINED = 1
) (
    input  logic                              ClkxCI,
    input  logic                              RstxRI,
    input  logic                              EnxSI,
    input  logic                              InValidxSI,
    input  logic [N*SHARES-1:0]               _XxDI,
    input  logic [N*SHARES-1:0]               _YxDI,
    input  logic [N*num_pairs(SHARES)-1:0]    _ZxDI,
    output logic [N*SHARES-1:0]               _QxDO,
    output logic                              OutValidxSO
);
    if (!((N == 2 || N == 4) && SHARES >= 2 && SHARES <= 4 && POLY[N])) begin : g_bad
        $error("dom_shared_mul_gf2n: illegal N, SHARES or POLY");
    end

    logic [N-1:0] term [SHARES][SHARES];

    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            logic [N-1:0] prod;
            gf2n_mul #(.N(N), .POLY(POLY)) u_mul (
                .a(_XxDI[i*N +: N]),
                .b(_YxDI[j*N +: N]),
                .q(prod)
            );
            if (i != j) begin : g_cross
                // Masked before its own register so no unmasked cross sum ever exists
                logic [N-1:0] c_q;
                always_ff @(posedge ClkxCI or posedge RstxRI)
                    if (RstxRI) c_q <= '0;
                    else if (EnxSI) c_q <= prod ^ _ZxDI[pair_idx(i, j, SHARES)*N +: N];
                assign term[i][j] = c_q;
            end else if (PIPELINED) begin : g_inner_reg
                logic [N-1:0] i_q;
                always_ff @(posedge ClkxCI or posedge RstxRI)
                    if (RstxRI) i_q <= '0;
                    else if (EnxSI) i_q <= prod;
                assign term[i][j] = i_q;
            end else begin : g_inner_comb
                assign term[i][j] = prod;
            end
        end

        logic [N-1:0] q;
        always_comb begin
            q = '0;
            for (int k = 0; k < SHARES; k++) q ^= term[i][k];
        end
        assign _QxDO[i*N +: N] = q;
    end

    always_ff @(posedge ClkxCI or posedge RstxRI)
        if (RstxRI) OutValidxSO <= 1'b0;
        else if (EnxSI) OutValidxSO <= InValidxSI;
endmodule

// File: doc/dom_shared_mul_gf2n.md
# dom_shared_mul_gf2n

Parametrised domain-oriented-masking (DOM) multiplier over GF(2^N), N ∈ {2, 4}, for any share count ≥ 2. It adds a valid/enable pipeline so it can sit in stallable S-box datapaths. It is the generalised successor of the GF(2^2) shared multiplier and is used as the building block of the masked inversion stages. Each output share is a register-protected sum of inner-domain and freshly-masked cross-domain products. The XOR of all output shares equals the GF(2^N) product of the unmasked inputs.

## Interface
- N, 4, field width in bits; legal values 2 and 4.
- POLY, 5'b10011, irreducible polynomial (bit N set); N=2 uses 3'b111.
- SHARES, 2, number of shares; legal values 2 to 4.
- PIPELINED, 1, 1: inner-domain terms registered; 0: inner-domain terms combinational.
- ClkxCI  in  1  clock; all flops rising-edge.
- RstxRI  in  1  asynchronous, active-high reset.
- EnxSI  in  1  pipeline advance; no register updates when low.
- InValidxSI  in  1  input shares and randomness valid this cycle.
- _XxDI  in  N*SHARES  operand X shares; share i occupies bits [i*N +: N].
- _YxDI  in  N*SHARES  operand Y shares, same packing as _XxDI.
- _ZxDI  in  N*SHARES*(SHARES-1)/2  fresh randomness, one N-bit word per unordered pair (i<j), in lexicographic pair order.
- _QxDO  out  N*SHARES  product shares, same packing as _XxDI.
- OutValidxSO  out  1  _QxDO holds a valid product.

## Operation
- Each GF(2^N) product is polynomial-basis multiplication reduced modulo POLY.
- Cross-domain term, for i≠j: C_ij = X_i·Y_j ⊕ Z_p, where p is the pair index of {i,j}. The same Z_p masks both C_ij and C_ji.
- Every C_ij is captured in its own N-bit register (resharing). No cross-domain sum is formed before this register.
- Inner-domain term I_i = X_i·Y_i.
  - PIPELINED=1: I_i is registered alongside the C_ij.
  - PIPELINED=0: I_i is taken combinationally from the current inputs.
- Q_i = I_i ⊕ XOR over j≠i of reg(C_ij).
- Valid tracking:
  - OutValidxSO is a flop loaded with InValidxSI when EnxSI=1.
  - When EnxSI=0, all data and valid flops hold their values.
- InValidxSI=0 with EnxSI=1:
  - Data registers still load. This keeps the design free of mux-dependent leakage.
  - OutValidxSO goes 0 next cycle.
- Randomness is consumed only in cycles where EnxSI=1. The caller supplies fresh Z on every enabled valid cycle.
- Reset:
  - All C_ij registers, I_i registers and OutValidxSO clear to 0 immediately.
  - Consequently _QxDO = 0 during and after reset. For PIPELINED=0, _QxDO is 0 only if the X and Y inputs are 0.
  - Reset asserted mid-operation discards the in-flight product. No valid output is produced for it.
- Illegal N, SHARES or POLY (bit N clear): elaboration error.

## Timing
- Latency is 1 enabled cycle. Inputs sampled at edge k appear on _QxDO with OutValidxSO=1 after edge k.
- Throughput is one product per enabled cycle when PIPELINED=1.
- PIPELINED=0: X and Y must be held stable for the cycle following capture. Result validity during that cycle is the caller's responsibility; OutValidxSO still follows the 1-cycle rule.
- Stall:
  - With EnxSI low for any number of cycles, _QxDO and OutValidxSO hold.
  - When PIPELINED=0, _QxDO is unaffected by the stall itself but changes if X or Y change.
- Reset is asynchronous: outputs clear without a clock edge. Deassertion is synchronised by the integrator.

## Structure
- Shared package dom_pkg holds:
  - function num_pairs(SHARES);
  - function pair_idx(i, j);
  - function gf2n_mul(a, b, N, POLY);
  - constants POLY_GF4 = 3'b111 and POLY_GF16 = 5'b10011.
- Sub-module gf2n_mul is the combinational GF(2^N) multiplier. There are SHARES² instances, built with generate loops.
- The top-level body is generate loops for the pair registers, inner registers, XOR trees and the valid flop.

## Test plan
- Reset, N=4, SHARES=3, PIPELINED=1: hold RstxRI=1, toggle inputs -> _QxDO=0 and OutValidxSO=0. After release, X0=0x2, Y0=0x8, other shares 0, Z=0, EnxSI=1, InValidxSI=1 -> next cycle Q0=0x3, Q1=Q2=0, OutValidxSO=1.
- Masking, N=4, SHARES=3: X=0xF and Y=0xF split into random shares, random Z -> XOR of Q shares = 0xA, and no individual share equals 0xA in more than chance frequency over 1000 trials.
- Exhaustive, N=2, SHARES=2 and SHARES=4: all 16 (X,Y) pairs with random masks and random Z -> unmasked result matches a reference function (e.g. 2·2=3, 3·3=2), one result per cycle back-to-back.
- Stall: issue product A, drop EnxSI for 5 cycles while changing inputs and Z -> _QxDO and OutValidxSO unchanged. Re-enable -> next product appears 1 cycle later.
- Reset mid-stream: assert RstxRI asynchronously between edges while InValidxSI=1 -> OutValidxSO and _QxDO drop to 0 immediately, and no stale valid appears after release.
- PIPELINED=0, N=4, SHARES=2: hold X and Y for 2 cycles -> correct product with OutValidxSO=1 on the second cycle.
